cla_adder_arbiter: RTL

//  Shares one cla_adder instance among NUM_REQ requesters using round-robin arbitration.

---
 rtl/cla_adder_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cla_adder_arbiter.sv
// cla_adder_arbiter: round-robin sharing of one carry-lookahead adder among NUM_REQ requesters
module cla_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] g, p;
    logic [W:0]   c;
    // each carry is the group generate/propagate of all lower bits, so no carry feeds another
    always_comb begin
        logic gg, pp;
        g = a & b;
        p = a ^ b;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = 0; j <= i; j++) begin
                gg = g[j] | (p[j] & gg);
                pp = pp & p[j];
            end
            c[i+1] = gg | (pp & cin);
        end
        sum  = p ^ c[W-1:0];
        cout = c[W];
    end
endmodule

module cla_adder_arbiter #(
    parameter  int DATA_WID = 16,
    parameter  int NUM_REQ  = 4,
    localparam int ID_WID   = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_WID-1:0] req_in1,
    input  logic [NUM_REQ*DATA_WID-1:0] req_in2,
    input  logic [NUM_REQ-1:0]          req_carry_in,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_WID-1:0]           rsp_id,
    output logic [DATA_WID-1:0]         rsp_sum,
    output logic                        rsp_carry_out,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
    state_t              state_q, state_d;
    logic [ID_WID-1:0]   last_q, last_d, id_q, id_d, rsp_id_q, rsp_id_d, grant;
    logic [DATA_WID-1:0] in1_q, in1_d, in2_q, in2_d, sum_q, sum_d, sel1, sel2, add_sum;
    logic                cin_q, cin_d, cout_q, cout_d, valid_q, valid_d, selc, found, add_cout;
    int                  idx;
    cla_adder #(.W(DATA_WID)) u_add (
        .a    (in1_q),
        .b    (in2_q),
        .cin  (cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );
    // search downward in distance so the requester closest after last_q wins
    always_comb begin
        idx   = 0;
        grant = '0;
        found = 1'b0;
        sel1  = '0;
        sel2  = '0;
        selc  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                grant = ID_WID'(idx);
                found = 1'b1;
                sel1  = req_in1[idx*DATA_WID +: DATA_WID];
                sel2  = req_in2[idx*DATA_WID +: DATA_WID];
                selc  = req_carry_in[idx];
            end
        end
    end
    // FSM next state: accept in IDLE, capture adder result in ADD, hold until consumed in RESP
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        cin_d     = cin_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        rsp_id_d  = rsp_id_q;
        valid_d   = valid_q;
        req_ready = (rst_n && state_q == IDLE && found) ? NUM_REQ'(1) << grant : '0;
        if (state_q == IDLE && found) begin
            state_d = ADD;
            last_d  = grant;
            id_d    = grant;
            in1_d   = sel1;
            in2_d   = sel2;
            cin_d   = selc;
        end
        if (state_q == ADD) begin
            state_d  = RESP;
            sum_d    = add_sum;
            cout_d   = add_cout;
            rsp_id_d = id_q;
            valid_d  = 1'b1;
        end
        if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end
    // state and datapath registers; reset discards any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= ID_WID'(NUM_REQ - 1);
            id_q     <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            cin_q    <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            rsp_id_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            cin_q    <= cin_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            rsp_id_q <= rsp_id_d;
            valid_q  <= valid_d;
        end
    end
    assign rsp_valid     = valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_sum       = sum_q;
    assign rsp_carry_out = cout_q;
    assign busy          = state_q != IDLE;
endmodule
